multi_mc_gen: RTL and testbench
===============================

Name: multi_mc_gen

Overview:
Parametrised next-generation multicycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and writeback, and drives the datapath control lines.
- Extends the base multicycle controller with bne, addi, an illegal-opcode trap, a memory-ready wait handshake and a retired-instruction counter.
- Sits between the instruction register (Op field) and the multicycle datapath/memory.

Parameters:
STATE_W, 4, width of state register/S output (min 4; upper bits zero).
CNT_W, 16, width of InstrCount.
ENABLE_ADDI, 1, 1 = addi (001000) supported; 0 = addi treated as illegal.
USE_MEM_READY, 1, 1 = memory states wait on MemReady; 0 = MemReady ignored, treated as 1.

Ports:
Clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
Op  input  6  opcode from IR[31:26].
MemReady  input  1  memory access completes this cycle.
S  output  STATE_W  current state.
PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
PCSource, ALUOp, ALUSrcB  output  2 each  datapath selects.
IllegalOp  output  1  one-cycle trap pulse.
InstrCount  output  CNT_W  retired-instruction count.

Behaviour:
- State register and InstrCount clear asynchronously when reset=0. While reset=0, S=0 and every control output is forced 0.
- After release, state advances only on a rising Clk edge. Controls are decoded from the current state only (Moore); the sole exception is the MemReady gating in states 0, 3 and 5.
- Any control not listed for a state is 0.
- S0 Fetch: MemRead=1, IRWrite=MemReady, PCWrite=MemReady, ALUSrcB=01, ALUOp=00, PCSource=00. Stays in S0 while MemReady=0; goes to S1 when MemReady=1.
- S1 Decode: ALUSrcB=11. Next state by Op:
  - 100011 or 101011 -> S2
  - 000000 -> S6
  - 000100 or 000101 -> S8
  - 000010 -> S9
  - 001000 -> S10 (only if ENABLE_ADDI)
  - anything else -> S12
- S2 MemAddr: ALUSrcA=1, ALUSrcB=10. Next: lw -> S3, sw -> S5.
- S3 MemRd: MemRead=1, IorD=1. Holds until MemReady=1, then -> S4.
- S4 LwWB: RegWrite=1, MemtoReg=1, RegDst=0. Next -> S0.
- S5 MemWr: MemWrite=1, IorD=1. Holds until MemReady=1, then -> S0.
- S6 RExec: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next -> S7.
- S7 RWB: RegWrite=1, RegDst=1. Next -> S0.
- S8 Branch: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=1 iff Op=000101. Next -> S0.
- S9 Jump: PCWrite=1, PCSource=10. Next -> S0.
- S10 AddiExec: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next -> S11.
- S11 AddiWB: RegWrite=1, RegDst=0, MemtoReg=0. Next -> S0.
- S12 Trap: IllegalOp=1, PCWrite=1, PCSource=11 (exception vector). Next -> S0. Exactly one cycle.
- Op is sampled in S1 and S2 only; it is don't-care in all other states.
- Unused state codes (13..2^STATE_W-1) -> S0 on the next edge, with all controls 0.
- InstrCount increments by 1 on each transition into S0 from S4, S5, S7, S8, S9 or S11.
  - Not incremented from S12 or from an unused state.
  - Wraps modulo 2^CNT_W.
- Reset asserted mid-instruction (any state, any phase of Clk): immediate return to S0 with outputs 0. The first fetch begins on the first edge after release.
- With USE_MEM_READY=0: S0, S3 and S5 never stall; IRWrite=PCWrite=1 in S0.

Test Plan:
- Reset low 2 cycles, then Op=100011, MemReady=1 -> S sequence 0,1,2,3,4,0. In S4: RegWrite=1, MemtoReg=1. InstrCount=1.
- sw with MemReady=0 for 3 cycles in S5 -> S stays 5 for 3 cycles with MemWrite=1; advances to 0 on the cycle after MemReady=1.
- Op=000101 -> S 0,1,8,0 with PCWriteCond=1, BranchNe=1, PCSource=01. Repeat with Op=000100 -> BranchNe=0.
- Op=111111 -> S 0,1,12,0. IllegalOp high exactly 1 cycle with PCSource=11. InstrCount unchanged.
- ENABLE_ADDI=0, Op=001000 -> S12. ENABLE_ADDI=1 -> S 0,1,10,11,0 with RegWrite=1 in S11.
- Drop reset in S6 mid-cycle -> S=0 and all controls 0 immediately (asynchronous). CNT_W=2: 5 R-type instructions -> InstrCount=1 (wrap).

Source files
------------

// File: rtl/multi_mc_gen.sv
// ---------------------------------------------------------------------------
// multi_mc_gen
// Multicycle MIPS control unit (Moore FSM). Sequences fetch, decode,
// execute, memory and writeback for lw, sw, R-type, beq, bne, j and
// (optionally) addi. Any unrecognised opcode takes a one-cycle trap state
// that redirects the PC to the exception vector. Memory states can wait
// on a MemReady handshake. Also counts retired instructions.
//
// Ports
//   Clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   Op          opcode field IR[31:26]
//   MemReady    memory access completes this cycle
//   S           current state code (upper bits zero)
//   PCWrite .. RegDst          1-bit datapath controls
//   PCSource, ALUOp, ALUSrcB   2-bit datapath selects
//   IllegalOp   one-cycle trap pulse
//   InstrCount  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multi_mc_gen #(
    parameter int STATE_W       = 4,
    parameter int CNT_W         = 16,
    parameter int ENABLE_ADDI   = 1,
    parameter int USE_MEM_READY = 1
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic [STATE_W-1:0] S,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic               IllegalOp,
    output logic [CNT_W-1:0]   InstrCount
);

    // S_INVALID never sits in the register; it names every unused code
    // (13 .. 2^STATE_W-1) after decoding.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_LWWB    = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_TRAP    = 4'd12,
        S_INVALID = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [STATE_W-1:0] state_r;
    logic [CNT_W-1:0]   instr_cnt_r;
    logic               bne_r;
    state_e             cur_s;
    state_e             nxt_s;
    logic               ready_s;
    logic               addi_ok_s;
    logic               retire_s;

    assign ready_s   = (USE_MEM_READY != 0) ? MemReady : 1'b1;
    assign addi_ok_s = (ENABLE_ADDI != 0);

    // Map the raw state register onto a named state; unused codes collapse to S_INVALID.
    always_comb begin
        cur_s = S_INVALID;
        if (state_r <= STATE_W'(4'd12)) begin
            cur_s = state_e'(state_r[3:0]);
        end else begin
            cur_s = S_INVALID;
        end
    end

    // Next-state selection and retirement detection.
    always_comb begin
        nxt_s    = S_FETCH;
        retire_s = 1'b0;
        case (cur_s)
            S_FETCH: begin
                if (ready_s) nxt_s = S_DECODE;
                else         nxt_s = S_FETCH;
            end
            S_DECODE: begin
                if ((Op == OP_LW) || (Op == OP_SW))        nxt_s = S_MEMADDR;
                else if (Op == OP_RTYPE)                   nxt_s = S_REXEC;
                else if ((Op == OP_BEQ) || (Op == OP_BNE)) nxt_s = S_BRANCH;
                else if (Op == OP_J)                       nxt_s = S_JUMP;
                else if ((Op == OP_ADDI) && addi_ok_s)     nxt_s = S_ADDIEX;
                else                                       nxt_s = S_TRAP;
            end
            S_MEMADDR: begin
                if (Op == OP_SW) nxt_s = S_MEMWR;
                else             nxt_s = S_MEMRD;
            end
            S_MEMRD: begin
                if (ready_s) nxt_s = S_LWWB;
                else         nxt_s = S_MEMRD;
            end
            S_LWWB: begin
                nxt_s    = S_FETCH;
                retire_s = 1'b1;
            end
            S_MEMWR: begin
                if (ready_s) begin
                    nxt_s    = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    nxt_s    = S_MEMWR;
                end
            end
            S_REXEC:  nxt_s = S_RWB;
            S_RWB: begin
                nxt_s    = S_FETCH;
                retire_s = 1'b1;
            end
            S_BRANCH: begin
                nxt_s    = S_FETCH;
                retire_s = 1'b1;
            end
            S_JUMP: begin
                nxt_s    = S_FETCH;
                retire_s = 1'b1;
            end
            S_ADDIEX: nxt_s = S_ADDIWB;
            S_ADDIWB: begin
                nxt_s    = S_FETCH;
                retire_s = 1'b1;
            end
            S_TRAP:   nxt_s = S_FETCH;
            default:  nxt_s = S_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) state_r <= '0;
        else        state_r <= STATE_W'(nxt_s);
    end

    // Remember bne vs beq at decode so the branch state does not depend on Op.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)                  bne_r <= 1'b0;
        else if (cur_s == S_DECODE)  bne_r <= (Op == OP_BNE);
        else                         bne_r <= bne_r;
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset)        instr_cnt_r <= '0;
        else if (retire_s) instr_cnt_r <= instr_cnt_r + CNT_W'(1'b1);
        else               instr_cnt_r <= instr_cnt_r;
    end

    assign S          = state_r;
    assign InstrCount = instr_cnt_r;

    // Moore control decode; held at zero while reset is asserted because S0 would otherwise read memory.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        IllegalOp   = 1'b0;
        if (!reset) begin
            PCWrite = 1'b0;
        end else begin
            case (cur_s)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = ready_s;
                    PCWrite = ready_s;
                    ALUSrcB = 2'b01;
                end
                S_DECODE:  ALUSrcB = 2'b11;
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_LWWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_REXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNe    = bne_r;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB:  RegWrite = 1'b1;
                S_TRAP: begin
                    IllegalOp = 1'b1;
                    PCWrite   = 1'b1;
                    PCSource  = 2'b11;
                end
                default:   IllegalOp = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_mc_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_mc_gen
// Scoreboarded bench. Two instances: u0 with default parameters and u1 with
// addi disabled, MemReady ignored, a 2-bit counter and a 5-bit state. The
// driver issues whole instructions, derives the state path from the opcode
// and pushes one expected (S, controls, InstrCount) entry per cycle; a
// monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_multi_mc_gen;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic       Clk = 1'b0;
    logic       reset0 = 1'b0;
    logic       reset1 = 1'b0;
    logic [5:0] Op = 6'b000000;
    logic       MemReady = 1'b0;

    wire [3:0]  s0;
    wire [4:0]  s1;
    wire [17:0] ctl0;
    wire [17:0] ctl1;
    wire [15:0] cnt0;
    wire [1:0]  cnt1;

    always #5 Clk = ~Clk;

    multi_mc_gen u0 (
        .Clk(Clk), .reset(reset0), .Op(Op), .MemReady(MemReady), .S(s0),
        .PCWrite(ctl0[17]), .PCWriteCond(ctl0[16]), .BranchNe(ctl0[15]),
        .IorD(ctl0[14]), .MemRead(ctl0[13]), .MemWrite(ctl0[12]),
        .IRWrite(ctl0[11]), .MemtoReg(ctl0[10]), .ALUSrcA(ctl0[9]),
        .RegWrite(ctl0[8]), .RegDst(ctl0[7]), .PCSource(ctl0[6:5]),
        .ALUOp(ctl0[4:3]), .ALUSrcB(ctl0[2:1]), .IllegalOp(ctl0[0]),
        .InstrCount(cnt0)
    );

    multi_mc_gen #(.STATE_W(5), .CNT_W(2), .ENABLE_ADDI(0), .USE_MEM_READY(0)) u1 (
        .Clk(Clk), .reset(reset1), .Op(Op), .MemReady(MemReady), .S(s1),
        .PCWrite(ctl1[17]), .PCWriteCond(ctl1[16]), .BranchNe(ctl1[15]),
        .IorD(ctl1[14]), .MemRead(ctl1[13]), .MemWrite(ctl1[12]),
        .IRWrite(ctl1[11]), .MemtoReg(ctl1[10]), .ALUSrcA(ctl1[9]),
        .RegWrite(ctl1[8]), .RegDst(ctl1[7]), .PCSource(ctl1[6:5]),
        .ALUOp(ctl1[4:3]), .ALUSrcB(ctl1[2:1]), .IllegalOp(ctl1[0]),
        .InstrCount(cnt1)
    );

    typedef struct {
        logic [7:0]  s;
        logic [17:0] ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   sel    = 0;
    bit   cfg_mr   = 1'b1;
    bit   cfg_addi = 1'b1;
    int   cnt_mask = 16'hFFFF;
    int   cnt_m    = 0;

    logic [7:0]  act_s;
    logic [17:0] act_ctl;
    logic [15:0] act_cnt;

    always_comb begin
        if (sel == 0) begin
            act_s   = {4'b0000, s0};
            act_ctl = ctl0;
            act_cnt = cnt0;
        end else begin
            act_s   = {3'b000, s1};
            act_ctl = ctl1;
            act_cnt = {14'd0, cnt1};
        end
    end

    // Control lines each state must drive, straight from the state table.
    function automatic logic [17:0] ctl_exp(input int st, input bit rdy, input bit bne);
        bit pcw = 0, pcwc = 0, bn = 0, iord = 0, mr = 0, mw = 0, irw = 0;
        bit m2r = 0, asa = 0, rw = 0, rd = 0, ill = 0;
        bit [1:0] pcs = 2'b00, aop = 2'b00, asb = 2'b00;
        case (st)
            0:  begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bn = bne; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            12: begin ill = 1; pcw = 1; pcs = 2'b11; end
            default: ill = 0;
        endcase
        return {pcw, pcwc, bn, iord, mr, mw, irw, m2r, asa, rw, rd, pcs, aop, asb, ill};
    endfunction

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_chk++;
            if (act_s !== e.s || act_ctl !== e.ctl || act_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL cycle t=%0t dut%0d: got S=%0d ctl=%h cnt=%0d, expected S=%0d ctl=%h cnt=%0d",
                         $time, sel, act_s, act_ctl, act_cnt, e.s, e.ctl, e.cnt);
            end
        end
    end

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic set_rst(input bit v);
        if (sel == 0) reset0 = v;
        else          reset1 = v;
    endtask

    task automatic push(input int st, input bit rdy, input bit bne);
        exp_t e;
        e.s   = 8'(st);
        e.ctl = ctl_exp(st, rdy, bne);
        e.cnt = 16'(cnt_m);
        q.push_back(e);
    endtask

    task automatic push_zero();
        exp_t e;
        e.s   = 8'd0;
        e.ctl = 18'd0;
        e.cnt = 16'd0;
        q.push_back(e);
    endtask

    task automatic cyc(input logic [5:0] op_v, input bit rdy_v, input int st, input bit bne_v);
        @(posedge Clk);
        #1;
        set_rst(1'b1);
        Op       = op_v;
        MemReady = rdy_v;
        push(st, cfg_mr ? rdy_v : 1'b1, bne_v);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            set_rst(1'b0);
            Op       = rnd_op();
            MemReady = 1'($urandom);
            push_zero();
        end
        cnt_m = 0;
    endtask

    // A memory-wait state: k stall cycles then completion (no stalls if MemReady is ignored).
    task automatic mem_wait(input int st, input int k);
        if (cfg_mr) begin
            for (int i = 0; i < k; i++) cyc(rnd_op(), 1'b0, st, 1'b0);
            cyc(rnd_op(), 1'b1, st, 1'b0);
        end else begin
            cyc(rnd_op(), 1'($urandom), st, 1'b0);
        end
    endtask

    // One whole instruction: state path chosen by opcode class.
    task automatic run_instr(input logic [5:0] op_v, input int k0, input int km);
        bit ret = 1'b1;
        mem_wait(0, k0);
        cyc(op_v, 1'($urandom), 1, 1'b0);
        if (op_v == OP_LW) begin
            cyc(op_v, 1'($urandom), 2, 1'b0);
            mem_wait(3, km);
            cyc(rnd_op(), 1'($urandom), 4, 1'b0);
        end else if (op_v == OP_SW) begin
            cyc(op_v, 1'($urandom), 2, 1'b0);
            mem_wait(5, km);
        end else if (op_v == OP_R) begin
            cyc(rnd_op(), 1'($urandom), 6, 1'b0);
            cyc(rnd_op(), 1'($urandom), 7, 1'b0);
        end else if (op_v == OP_BEQ || op_v == OP_BNE) begin
            cyc(rnd_op(), 1'($urandom), 8, op_v == OP_BNE);
        end else if (op_v == OP_J) begin
            cyc(rnd_op(), 1'($urandom), 9, 1'b0);
        end else if (op_v == OP_ADDI && cfg_addi) begin
            cyc(rnd_op(), 1'($urandom), 10, 1'b0);
            cyc(rnd_op(), 1'($urandom), 11, 1'b0);
        end else begin
            cyc(rnd_op(), 1'($urandom), 12, 1'b0);
            ret = 1'b0;
        end
        if (ret) cnt_m = (cnt_m + 1) & cnt_mask;
    endtask

    task automatic run_random(input int n);
        logic [5:0] ops [8];
        logic [5:0] op_v;
        int idx;
        ops = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW, 6'b111111};
        for (int i = 0; i < n; i++) begin
            idx = $urandom_range(0, 8);
            if (idx == 8) op_v = rnd_op();
            else          op_v = ops[idx];
            run_instr(op_v, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Default configuration.
        sel = 0; cfg_mr = 1'b1; cfg_addi = 1'b1; cnt_mask = 16'hFFFF;
        reset_cycles(2);
        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 3);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_ADDI, 1, 0);
        run_instr(OP_R, 0, 0);
        run_instr(OP_J, 2, 0);
        run_random(60);

        // Asynchronous reset in the middle of an R-type execute cycle.
        mem_wait(0, 0);
        cyc(OP_R, 1'b1, 1, 1'b0);
        @(posedge Clk);
        #1;
        Op = rnd_op();
        MemReady = 1'b1;
        n_chk++;
        if (act_s !== 8'd6) begin
            n_fail++;
            $display("FAIL pre_reset_state: got S=%0d, expected 6", act_s);
        end
        #2;
        set_rst(1'b0);
        #1;
        n_chk++;
        if (act_s !== 8'd0 || act_ctl !== 18'd0 || act_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got S=%0d ctl=%h cnt=%0d, expected all zero", act_s, act_ctl, act_cnt);
        end
        push_zero();
        reset_cycles(1);
        run_instr(OP_LW, 0, 1);
        run_instr(OP_R, 0, 0);

        // Second configuration: addi traps, MemReady ignored, 2-bit counter.
        @(negedge Clk);
        #1;
        reset0 = 1'b0;
        sel = 1; cfg_mr = 1'b0; cfg_addi = 1'b0; cnt_mask = 3;
        reset_cycles(2);
        run_instr(OP_ADDI, 0, 0);
        for (int i = 0; i < 5; i++) run_instr(OP_R, 0, 0);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_LW, 0, 0);
        run_random(30);

        @(negedge Clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
